// File: rtl/fc_dot_engine.sv
// Weight-stationary dot-product engine: serial ifmap beats against NUM_PE held weights,
// multi-tile accumulation, bias, optional ReLU and shift/saturate requantiser on a valid/ready output.
module fc_dot_engine #(
  parameter int NUM_PE = 120,
  parameter int DATA_W = 8,
  parameter int PSUM_W = 32,
  parameter int SIGNED = 0,
  parameter int SHIFT  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PE-1:0][DATA_W-1:0] weight_i,
  input  logic                          weight_load_i,
  input  logic [PSUM_W-1:0]             bias_i,
  input  logic                          relu_en_i,
  input  logic [DATA_W-1:0]             ifmap_i,
  input  logic                          ifmap_valid_i,
  input  logic                          tile_last_i,
  output logic                          ifmap_ready_o,
  output logic [DATA_W-1:0]             ifmap_o,
  output logic                          ifmap_valid_o,
  output logic [PSUM_W-1:0]             psum_o,
  output logic [DATA_W-1:0]             act_o,
  output logic                          psum_valid_o,
  input  logic                          psum_ready_i,
  output logic                          err_o
);

  // state   | meaning
  // W_EMPTY | no valid weights, waiting for the first load
  // RUN     | accepting ifmap beats against the held weights
  // WAIT_W  | tile done but vector not finished; partial sum kept, waiting for next tile
  // OUT     | result presented, waiting for the consumer handshake
  typedef enum logic [1:0] {W_EMPTY, RUN, WAIT_W, OUT} state_e;

  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam int IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PE - 1);
  localparam int SAT_HI_I  = IS_SIGNED ? (2**(DATA_W-1)) - 1 : (2**DATA_W) - 1;
  localparam int SAT_LO_I  = IS_SIGNED ? -(2**(DATA_W-1)) : 0;
  localparam logic signed [PSUM_W-1:0] SAT_HI = PSUM_W'(SAT_HI_I);
  localparam logic signed [PSUM_W-1:0] SAT_LO = PSUM_W'(SAT_LO_I);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [PSUM_W-1:0]               acc_q, acc_d;
  logic [NUM_PE-1:0][DATA_W-1:0]   w_q, w_d;
  logic [PSUM_W-1:0]               psum_q, psum_d;
  logic [DATA_W-1:0]               act_q, act_d;
  logic                            psum_valid_q, psum_valid_d;
  logic [DATA_W-1:0]               ifmap_q, ifmap_d;
  logic                            ifmap_valid_q, ifmap_valid_d;
  logic                            err_q, err_d;

  logic                            accept;
  logic                            last_beat;
  logic signed [DATA_W:0]          x_ext, w_ext;
  logic signed [2*DATA_W+1:0]      prod_full;
  logic [PSUM_W-1:0]               prod_ext;
  logic [PSUM_W-1:0]               acc_sum;
  logic signed [PSUM_W-1:0]        res_s, relu_s, shift_s;
  logic [DATA_W-1:0]               act_sat;

  assign accept    = ifmap_valid_i & (state_q == RUN);
  assign last_beat = (idx_q == IDX_LAST);

  // One extra operand bit lets a single signed multiplier serve both signedness modes.
  assign x_ext     = IS_SIGNED ? {ifmap_i[DATA_W-1], ifmap_i} : {1'b0, ifmap_i};
  assign w_ext     = IS_SIGNED ? {w_q[idx_q][DATA_W-1], w_q[idx_q]} : {1'b0, w_q[idx_q]};
  assign prod_full = x_ext * w_ext;
  assign prod_ext  = {{(PSUM_W-2*DATA_W-2){prod_full[2*DATA_W+1]}}, prod_full};
  assign acc_sum   = acc_q + prod_ext;
  assign res_s     = acc_sum + bias_i;
  assign relu_s    = (relu_en_i && IS_SIGNED && res_s[PSUM_W-1]) ? '0 : res_s;
  assign shift_s   = relu_s >>> SHIFT;

  // The result is always read as signed because the bias is signed in both modes.
  always_comb begin
    act_sat = shift_s[DATA_W-1:0];
    if (shift_s > SAT_HI) begin
      act_sat = SAT_HI[DATA_W-1:0];
    end else if (shift_s < SAT_LO) begin
      act_sat = SAT_LO[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    w_d           = w_q;
    psum_d        = psum_q;
    act_d         = act_q;
    psum_valid_d  = psum_valid_q;
    ifmap_d       = accept ? ifmap_i : ifmap_q;
    ifmap_valid_d = accept;
    err_d         = 1'b0;
    case (state_q)
      W_EMPTY, WAIT_W: begin
        if (weight_load_i) begin
          w_d     = weight_i;
          state_d = RUN;
        end
      end
      RUN: begin
        err_d = weight_load_i;
        if (accept) begin
          if (last_beat) begin
            idx_d = '0;
            if (tile_last_i) begin
              psum_d       = res_s;
              act_d        = act_sat;
              psum_valid_d = 1'b1;
              acc_d        = '0;
              state_d      = OUT;
            end else begin
              acc_d   = acc_sum;
              state_d = WAIT_W;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            acc_d = acc_sum;
          end
        end
      end
      OUT: begin
        err_d = weight_load_i;
        if (psum_valid_q && psum_ready_i) begin
          psum_valid_d = 1'b0;
          state_d      = RUN;
        end
      end
      default: state_d = W_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= W_EMPTY;
      idx_q         <= '0;
      acc_q         <= '0;
      psum_q        <= '0;
      act_q         <= '0;
      psum_valid_q  <= 1'b0;
      ifmap_q       <= '0;
      ifmap_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      psum_q        <= psum_d;
      act_q         <= act_d;
      psum_valid_q  <= psum_valid_d;
      ifmap_q       <= ifmap_d;
      ifmap_valid_q <= ifmap_valid_d;
      err_q         <= err_d;
    end
  end

  // Weight storage is qualified by state, so it needs no reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign ifmap_ready_o = (state_q == RUN);
  assign ifmap_o       = ifmap_q;
  assign ifmap_valid_o = ifmap_valid_q;
  assign psum_o        = psum_q;
  assign act_o         = act_q;
  assign psum_valid_o  = psum_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fc_dot_engine.sv
// Directed bench for fc_dot_engine: an unsigned and a signed instance share all inputs.
module tb_fc_dot_engine;

  localparam int NPE = 4;
  localparam int DW  = 8;
  localparam int PW  = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NPE-1:0][DW-1:0]  weight_i = '0;
  logic                    weight_load_i = 1'b0;
  logic [PW-1:0]           bias_i = '0;
  logic                    relu_en_i = 1'b0;
  logic [DW-1:0]           ifmap_i = '0;
  logic                    ifmap_valid_i = 1'b0;
  logic                    tile_last_i = 1'b0;
  logic                    psum_ready_i = 1'b0;

  logic                    ifmap_ready_o, ifmap_valid_o, psum_valid_o, err_o;
  logic [DW-1:0]           ifmap_o, act_o;
  logic [PW-1:0]           psum_o;
  logic                    ifmap_ready_o_s, ifmap_valid_o_s, psum_valid_o_s, err_o_s;
  logic [DW-1:0]           ifmap_o_s, act_o_s;
  logic [PW-1:0]           psum_o_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_dot_engine #(.NUM_PE(NPE), .DATA_W(DW), .PSUM_W(PW), .SIGNED(0), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .weight_i(weight_i), .weight_load_i(weight_load_i),
    .bias_i(bias_i), .relu_en_i(relu_en_i), .ifmap_i(ifmap_i), .ifmap_valid_i(ifmap_valid_i),
    .tile_last_i(tile_last_i), .ifmap_ready_o(ifmap_ready_o), .ifmap_o(ifmap_o),
    .ifmap_valid_o(ifmap_valid_o), .psum_o(psum_o), .act_o(act_o), .psum_valid_o(psum_valid_o),
    .psum_ready_i(psum_ready_i), .err_o(err_o)
  );

  fc_dot_engine #(.NUM_PE(NPE), .DATA_W(DW), .PSUM_W(PW), .SIGNED(1), .SHIFT(0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .weight_i(weight_i), .weight_load_i(weight_load_i),
    .bias_i(bias_i), .relu_en_i(relu_en_i), .ifmap_i(ifmap_i), .ifmap_valid_i(ifmap_valid_i),
    .tile_last_i(tile_last_i), .ifmap_ready_o(ifmap_ready_o_s), .ifmap_o(ifmap_o_s),
    .ifmap_valid_o(ifmap_valid_o_s), .psum_o(psum_o_s), .act_o(act_o_s), .psum_valid_o(psum_valid_o_s),
    .psum_ready_i(psum_ready_i), .err_o(err_o_s)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_w(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
    weight_i[0] = a;
    weight_i[1] = b;
    weight_i[2] = c;
    weight_i[3] = d;
    weight_load_i = 1'b1;
    tick();
    weight_load_i = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] x, input logic last);
    ifmap_i = x;
    ifmap_valid_i = 1'b1;
    tile_last_i = last;
    tick();
    ifmap_valid_i = 1'b0;
    tile_last_i = 1'b0;
  endtask

  task automatic take_result();
    psum_ready_i = 1'b1;
    tick();
    psum_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifmap_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", ifmap_ready_o); end
    checks++; if (psum_valid_o !== 1'b0) begin errors++; $display("FAIL rst_psum_valid: got %0b expected 0", psum_valid_o); end
    checks++; if (psum_o !== 32'd0) begin errors++; $display("FAIL rst_psum: got %0h expected 0", psum_o); end
    checks++; if (act_o !== 8'd0) begin errors++; $display("FAIL rst_act: got %0h expected 0", act_o); end
    checks++; if (ifmap_valid_o !== 1'b0 || ifmap_o !== 8'd0) begin errors++; $display("FAIL rst_passthru: got %0b/%0h expected 0/0", ifmap_valid_o, ifmap_o); end
    checks++; if (err_o !== 1'b0 || err_o_s !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b/%0b expected 0/0", err_o, err_o_s); end
    checks++; if (ifmap_ready_o_s !== 1'b0 || psum_valid_o_s !== 1'b0) begin errors++; $display("FAIL rst_signed: got %0b/%0b expected 0/0", ifmap_ready_o_s, psum_valid_o_s); end
  endtask

  task automatic test_single_tile();
    do_reset();
    bias_i = '0;
    relu_en_i = 1'b0;
    load_w(8'd1, 8'd2, 8'd3, 8'd4);
    checks++; if (ifmap_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", ifmap_ready_o); end
    for (int i = 0; i < 4; i++) begin
      beat(8'd1, i == 3);
      checks++; if (ifmap_valid_o !== 1'b1 || ifmap_o !== 8'd1) begin errors++; $display("FAIL single_passthru beat %0d: got %0b/%0h expected 1/1", i, ifmap_valid_o, ifmap_o); end
      checks++; if (psum_valid_o !== (i == 3)) begin errors++; $display("FAIL single_valid_timing beat %0d: got %0b expected %0b", i, psum_valid_o, i == 3); end
    end
    checks++; if (psum_o !== 32'd10) begin errors++; $display("FAIL single_psum: got %0d expected 10", psum_o); end
    checks++; if (act_o !== 8'd10) begin errors++; $display("FAIL single_act: got %0d expected 10", act_o); end
    tick();
    checks++; if (ifmap_valid_o !== 1'b0) begin errors++; $display("FAIL single_passthru_end: got %0b expected 0", ifmap_valid_o); end
    take_result();
    checks++; if (psum_valid_o !== 1'b0 || ifmap_ready_o !== 1'b1) begin errors++; $display("FAIL single_handshake: got valid %0b ready %0b expected 0/1", psum_valid_o, ifmap_ready_o); end
  endtask

  task automatic test_multi_tile();
    do_reset();
    bias_i = '0;
    load_w(8'd1, 8'd1, 8'd1, 8'd1);
    beat(8'd2, 1'b1);
    beat(8'd2, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd2, 1'b0);
    checks++; if (ifmap_ready_o !== 1'b0 || psum_valid_o !== 1'b0) begin errors++; $display("FAIL multi_wait: got ready %0b valid %0b expected 0/0", ifmap_ready_o, psum_valid_o); end
    tick();
    tick();
    checks++; if (ifmap_ready_o !== 1'b0) begin errors++; $display("FAIL multi_wait_hold: got %0b expected 0", ifmap_ready_o); end
    load_w(8'd2, 8'd2, 8'd2, 8'd2);
    checks++; if (err_o !== 1'b0 || ifmap_ready_o !== 1'b1) begin errors++; $display("FAIL multi_reload: got err %0b ready %0b expected 0/1", err_o, ifmap_ready_o); end
    for (int i = 0; i < 4; i++) beat(8'd1, i == 3);
    checks++; if (psum_valid_o !== 1'b1 || psum_o !== 32'd16) begin errors++; $display("FAIL multi_psum: got %0b/%0d expected 1/16", psum_valid_o, psum_o); end
    take_result();
  endtask

  task automatic test_signed();
    do_reset();
    bias_i = '0;
    relu_en_i = 1'b1;
    load_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) beat(8'd5, i == 3);
    relu_en_i = 1'b0;
    checks++; if (psum_o_s !== 32'hFFFF_FFEC) begin errors++; $display("FAIL signed_relu_psum: got %0h expected ffffffec", psum_o_s); end
    checks++; if (act_o_s !== 8'h00) begin errors++; $display("FAIL signed_relu_act: got %0h expected 0", act_o_s); end
    checks++; if (psum_o !== 32'd5100 || act_o !== 8'hFF) begin errors++; $display("FAIL unsigned_view: got %0d/%0h expected 5100/ff", psum_o, act_o); end
    take_result();
    for (int i = 0; i < 4; i++) beat(8'd5, i == 3);
    checks++; if (psum_o_s !== 32'hFFFF_FFEC) begin errors++; $display("FAIL signed_norelu_psum: got %0h expected ffffffec", psum_o_s); end
    checks++; if (act_o_s !== 8'hEC) begin errors++; $display("FAIL signed_norelu_act: got %0h expected ec", act_o_s); end
    take_result();
  endtask

  task automatic test_backpressure();
    do_reset();
    bias_i = '0;
    load_w(8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 4; i++) beat(8'd1, i == 3);
    ifmap_i = 8'd9;
    ifmap_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (psum_valid_o !== 1'b1 || psum_o !== 32'd10 || act_o !== 8'd10) begin errors++; $display("FAIL bp_hold cyc %0d: got %0b/%0d/%0d expected 1/10/10", i, psum_valid_o, psum_o, act_o); end
      checks++; if (ifmap_ready_o !== 1'b0 || ifmap_valid_o !== 1'b0) begin errors++; $display("FAIL bp_block cyc %0d: got ready %0b pass %0b expected 0/0", i, ifmap_ready_o, ifmap_valid_o); end
    end
    ifmap_valid_i = 1'b0;
    take_result();
    bias_i = 32'd1000;
    beat(8'd0, 1'b0);
    tick();
    tick();
    beat(8'd0, 1'b0);
    beat(8'd0, 1'b0);
    tick();
    checks++; if (psum_valid_o !== 1'b0) begin errors++; $display("FAIL bp_bubble_early: got %0b expected 0", psum_valid_o); end
    bias_i = '0;
    beat(8'd1, 1'b1);
    checks++; if (psum_valid_o !== 1'b1 || psum_o !== 32'd4 || act_o !== 8'd4) begin errors++; $display("FAIL bp_next_vector: got %0b/%0d/%0d expected 1/4/4", psum_valid_o, psum_o, act_o); end
    take_result();
  endtask

  task automatic test_saturation();
    do_reset();
    bias_i = '0;
    load_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) beat(8'hFF, i == 3);
    checks++; if (psum_o !== 32'd260100 || act_o !== 8'hFF) begin errors++; $display("FAIL sat_high: got %0d/%0h expected 260100/ff", psum_o, act_o); end
    take_result();
    bias_i = 32'hFFFC_07FC;
    for (int i = 0; i < 4; i++) beat(8'hFF, i == 3);
    checks++; if (psum_o !== 32'd0 || act_o !== 8'h00) begin errors++; $display("FAIL sat_bias_zero: got %0h/%0h expected 0/0", psum_o, act_o); end
    take_result();
    bias_i = 32'hFFFC_07FB;
    for (int i = 0; i < 4; i++) beat(8'hFF, i == 3);
    checks++; if (psum_o !== 32'hFFFF_FFFF || act_o !== 8'h00) begin errors++; $display("FAIL sat_low: got %0h/%0h expected ffffffff/0", psum_o, act_o); end
    take_result();
    bias_i = '0;
  endtask

  task automatic test_error_reset();
    do_reset();
    load_w(8'd1, 8'd2, 8'd3, 8'd4);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_legal_load: got %0b expected 0", err_o); end
    load_w(8'd9, 8'd9, 8'd9, 8'd9);
    checks++; if (err_o !== 1'b1 || ifmap_ready_o !== 1'b1) begin errors++; $display("FAIL err_run_pulse: got err %0b ready %0b expected 1/1", err_o, ifmap_ready_o); end
    tick();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_run_width: got %0b expected 0", err_o); end
    for (int i = 0; i < 4; i++) beat(8'd1, i == 3);
    checks++; if (psum_o !== 32'd10) begin errors++; $display("FAIL err_weights_kept: got %0d expected 10", psum_o); end
    load_w(8'd7, 8'd7, 8'd7, 8'd7);
    checks++; if (err_o !== 1'b1 || psum_valid_o !== 1'b1) begin errors++; $display("FAIL err_out_pulse: got err %0b valid %0b expected 1/1", err_o, psum_valid_o); end
    take_result();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_out_width: got %0b expected 0", err_o); end
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (ifmap_ready_o !== 1'b0 || psum_valid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got %0b/%0b/%0b expected 0/0/0", ifmap_ready_o, psum_valid_o, err_o); end
    checks++; if (psum_o !== 32'd0 || act_o !== 8'd0 || ifmap_o !== 8'd0 || ifmap_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_data: got %0h/%0h/%0h/%0b expected 0/0/0/0", psum_o, act_o, ifmap_o, ifmap_valid_o); end
    ifmap_i = 8'd3;
    ifmap_valid_i = 1'b1;
    tick();
    ifmap_valid_i = 1'b0;
    checks++; if (ifmap_ready_o !== 1'b0 || ifmap_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_noload: got ready %0b pass %0b expected 0/0", ifmap_ready_o, ifmap_valid_o); end
    load_w(8'd1, 8'd1, 8'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      beat(8'd2, i == 3);
      checks++; if (psum_valid_o !== (i == 3)) begin errors++; $display("FAIL midreset_idx beat %0d: got %0b expected %0b", i, psum_valid_o, i == 3); end
    end
    checks++; if (psum_o !== 32'd8) begin errors++; $display("FAIL midreset_clean_sum: got %0d expected 8", psum_o); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_signed();
    test_backpressure();
    test_saturation();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
